store_merge_unit: RTL and testbench

//  Store-side counterpart of the load masking path: performs sw/sh/sb to data memory.
//  For sh/sb it runs a read-modify-write, merging the low half/byte of the register operand

---
 rtl/store_merge_unit_if.sv | 18 +
 rtl/store_merge_unit.sv | 66 ++++++
 tb/tb_store_merge_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_merge_unit_if.sv
// store_merge_unit_if: control-side request/status and data-memory port of the store merge unit
//  start/ct/addr/wdata : store request from control (start sampled only when idle)
//  busy/done           : status back to control (done pulses with mem_wr)
//  mem_addr/mem_wdata/mem_wr/mem_rdata : synchronous data-memory port
interface store_merge_unit_if;
  logic        start;
  logic [1:0]  ct;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  modport slave (input start, ct, addr, wdata, mem_rdata, output mem_addr, mem_wdata, mem_wr, busy, done);
  modport master (output start, ct, addr, wdata, mem_rdata, input mem_addr, mem_wdata, mem_wr, busy, done);
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit: sw/sh/sb store path; sub-word stores read-modify-write the memory word
//  clk, reset_n : clock, asynchronous active-low reset
//  bus          : store_merge_unit_if.slave (request/status and data-memory port)
module store_merge_unit #(
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 4
) (
  input logic             clk,
  input logic             reset_n,
  store_merge_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0]      r_addr, w_addr, r_wdata, w_wdata, r_data, w_data;
  logic             r_half, w_half;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_half  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_data  <= w_data;
      r_half  <= w_half;
    end
  // ct 01/10 are the sub-word stores; ct[0] alone then tells half from byte
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_data  = r_data;
    w_half  = r_half;
    case (r_state)
      IDLE: if (bus.start) begin
        w_addr = bus.addr;
        w_data = bus.wdata;
        w_half = bus.ct[0];
        w_next = (bus.ct[0] ^ bus.ct[1]) ? READ : WRITE;
        w_cnt  = (bus.ct[0] ^ bus.ct[1]) ? CNT_W'(READ_LAT) : r_cnt;
        w_wdata = (bus.ct[0] ^ bus.ct[1]) ? r_wdata : bus.wdata;
      end
      READ: begin
        w_cnt  = r_cnt - 1'b1;
        w_next = (r_cnt == CNT_W'(1)) ? MERGE : READ;
      end
      MERGE: begin
        w_wdata = r_half ? {bus.mem_rdata[31:16], r_data[15:0]} : {bus.mem_rdata[31:8], r_data[7:0]};
        w_next  = WRITE;
      end
      default: w_next = IDLE;
    endcase
  end
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wr    = r_state == WRITE;
  assign bus.done      = r_state == WRITE;
  assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: drives READ_LAT=1 and READ_LAT=3 units in lockstep against a store-level model
module tb_store_merge_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  ct = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  int checks = 0;
  int failures = 0;
  logic        bz [2];
  logic        wr [2];
  logic        dn [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  int          erem [2];
  logic [31:0] ela [2];
  logic [31:0] eda [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 1 : 3;
    store_merge_unit_if sif();
    store_merge_unit #(.READ_LAT(L), .CNT_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(sif.slave));
    logic [31:0] mem [256];
    logic [31:0] mm [256];
    logic [31:0] pipe [L];
    int          rem = 0;
    int          wc = 0;
    logic [31:0] la;
    logic [31:0] ed;
    assign sif.start     = start;
    assign sif.ct        = ct;
    assign sif.addr      = addr;
    assign sif.wdata     = wdata;
    assign sif.mem_rdata = pipe[L-1];
    assign bz[g] = sif.busy;
    assign wr[g] = sif.mem_wr;
    assign dn[g] = sif.done;
    assign ma[g] = sif.mem_addr;
    assign mw[g] = sif.mem_wdata;
    assign erem[g] = rem;
    assign ela[g] = la;
    assign eda[g] = ed;
    initial for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hAABBCCDD;
      mm[i]  = 32'hAABBCCDD;
    end
    // synchronous memory: data for the address seen at an edge appears L cycles later
    always @(posedge clk) begin
      if (sif.mem_wr) mem[sif.mem_addr[7:0]] <= sif.mem_wdata;
      pipe[0] <= mem[sif.mem_addr[7:0]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      if (sif.mem_wr) wc <= wc + 1;
    end
    // store-level model: an accepted store occupies 1 (word) or L+2 (sub-word) cycles, writing in the last
    always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        rem <= 0;
        la  <= '0;
      end else if (rem == 0) begin
        if (start) begin
          rem <= (ct == 2'b01 || ct == 2'b10) ? L + 2 : 1;
          la  <= addr;
          ed  <= (ct == 2'b01) ? {mm[addr[7:0]][31:16], wdata[15:0]} :
                 (ct == 2'b10) ? {mm[addr[7:0]][31:8], wdata[7:0]} : wdata;
        end
      end else begin
        if (rem == 1) mm[la[7:0]] <= ed;
        rem <= rem - 1;
      end
  end
  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", n, k, a, e, $time);
    end
  endtask
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk("busy", k, 32'(bz[k]), 32'(erem[k] != 0));
      chk("mem_wr", k, 32'(wr[k]), 32'(erem[k] == 1));
      chk("done", k, 32'(dn[k]), 32'(erem[k] == 1));
      chk("mem_addr", k, ma[k], ela[k]);
      if (erem[k] == 1) chk("mem_wdata", k, mw[k], eda[k]);
    end
  task automatic go(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
    @(negedge clk);
    addr = a;
    wdata = d;
    ct = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    addr = 32'hDEAD_0000;
    wdata = 32'hFFFF_FFFF;
    ct = 2'b00;
  endtask
  task automatic wait_idle;
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = !bz[0] && !bz[1];
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_idle: busy still high after 40 cycles");
    end
  endtask
  task automatic zero_outs(input string n);
    for (int k = 0; k < 2; k++) begin
      chk({n, "_busy"}, k, 32'(bz[k]), 0);
      chk({n, "_wr"}, k, 32'(wr[k]), 0);
      chk({n, "_done"}, k, 32'(dn[k]), 0);
      chk({n, "_addr"}, k, ma[k], 0);
      chk({n, "_wdata"}, k, mw[k], 0);
    end
  endtask
  initial begin
    int w0, w1;
    repeat (3) @(negedge clk);
    zero_outs("reset");
    reset_n = 1'b1;
    go(32'h40, 32'h12345678, 2'b01);
    @(negedge clk);
    chk("sh_c1_addr", 0, ma[0], 32'h40);
    chk("sh_c1_wr", 0, 32'(wr[0]), 0);
    @(negedge clk);
    chk("sh_c2_wr", 0, 32'(wr[0]), 0);
    @(negedge clk);
    chk("sh_c3_wr", 0, 32'(wr[0]), 1);
    chk("sh_c3_done", 0, 32'(dn[0]), 1);
    chk("sh_c3_wdata", 0, mw[0], 32'hAABB5678);
    chk("sh_c3_addr", 0, ma[0], 32'h40);
    chk("sh_c3_wr_lat3", 1, 32'(wr[1]), 0);
    @(negedge clk);
    chk("sh_c4_busy", 0, 32'(bz[0]), 0);
    chk("sh_c4_busy_lat3", 1, 32'(bz[1]), 1);
    @(negedge clk);
    chk("sh_c5_wr_lat3", 1, 32'(wr[1]), 1);
    chk("sh_c5_wdata_lat3", 1, mw[1], 32'hAABB5678);
    wait_idle();
    chk("sh_mem", 0, u[0].mem[8'h40], 32'hAABB5678);
    chk("sh_mem", 1, u[1].mem[8'h40], 32'hAABB5678);
    go(32'h44, 32'h12345678, 2'b10);
    wait_idle();
    chk("sb_mem", 0, u[0].mem[8'h44], 32'hAABBCC78);
    chk("sb_mem", 1, u[1].mem[8'h44], 32'hAABBCC78);
    go(32'h48, 32'h12345678, 2'b00);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("sw00_wr", k, 32'(wr[k]), 1);
      chk("sw00_wdata", k, mw[k], 32'h12345678);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("sw00_busy_after", k, 32'(bz[k]), 0);
    go(32'h4C, 32'h12345678, 2'b11);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("sw11_wr", k, 32'(wr[k]), 1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("sw11_busy_after", k, 32'(bz[k]), 0);
      chk("sw11_mem", k, k == 0 ? u[0].mem[8'h4C] : u[1].mem[8'h4C], 32'h12345678);
    end
    w0 = u[0].wc;
    w1 = u[1].wc;
    @(negedge clk);
    addr = 32'h50;
    wdata = 32'h0000BEEF;
    ct = 2'b01;
    start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk("held_start_writes", 0, 32'(u[0].wc - w0), 2);
    chk("held_start_writes", 1, 32'(u[1].wc - w1), 1);
    chk("held_start_mem", 0, u[0].mem[8'h50], 32'hAABBBEEF);
    chk("held_start_mem", 1, u[1].mem[8'h50], 32'hAABBBEEF);
    w0 = u[0].wc;
    w1 = u[1].wc;
    go(32'h60, 32'h0000CAFE, 2'b01);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    zero_outs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_mem", 0, u[0].mem[8'h60], 32'hAABBCCDD);
    chk("abort_mem", 1, u[1].mem[8'h60], 32'hAABBCCDD);
    chk("abort_writes", 0, 32'(u[0].wc - w0), 0);
    chk("abort_writes", 1, 32'(u[1].wc - w1), 0);
    go(32'h64, 32'h0000CAFE, 2'b01);
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("merge_rst_wr", 1, 32'(wr[1]), 0);
    chk("merge_rst_busy", 1, 32'(bz[1]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("merge_rst_mem", 1, u[1].mem[8'h64], 32'hAABBCCDD);
    chk("merge_rst_mem", 0, u[0].mem[8'h64], 32'hAABBCAFE);
    chk("merge_rst_writes", 1, 32'(u[1].wc - w1), 0);
    for (int a = 8'h40; a < 8'h70; a += 4) begin
      chk("mem_vs_model", 0, u[0].mem[a], u[0].mm[a]);
      chk("mem_vs_model", 1, u[1].mem[a], u[1].mm[a]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
